// File: rtl/fsm.sv
// fsm: control FSM for a write-through, write-allocate cache between the CPU and main memory
module fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       hit,
    input  logic       Run,
    input  logic       RW,
    input  logic       Data_Ready,
    input  logic       Data_ReadyM,
    input  logic       Process_Data,
    output logic       SelecMemCPU,
    output logic       ReadEnableTag,
    output logic       ReadEnableData,
    output logic       gen_reset,
    output logic       write_enable_ram,
    output logic       enable_contadores,
    output logic       count_read,
    output logic [2:0] salida
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] TAG     = 3'd1;
    localparam logic [2:0] RD_HIT  = 3'd2;
    localparam logic [2:0] RD_MISS = 3'd3;
    localparam logic [2:0] WR_HIT  = 3'd4;
    localparam logic [2:0] WR_MISS = 3'd5;
    localparam logic [2:0] WR_THRU = 3'd6;

    logic [2:0] state;
    logic [2:0] state_nxt;

    // state register, cleared asynchronously while reset is low
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nxt;

    // next state: each state samples only the handshake it is waiting on
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = Run ? TAG : IDLE;
            TAG:     state_nxt = hit ? (RW ? WR_HIT : RD_HIT) : (RW ? WR_MISS : RD_MISS);
            RD_HIT:  state_nxt = Data_Ready ? IDLE : RD_HIT;
            RD_MISS: state_nxt = Data_ReadyM ? TAG : RD_MISS;
            WR_MISS: state_nxt = Data_ReadyM ? TAG : WR_MISS;
            WR_HIT:  state_nxt = WR_THRU;
            WR_THRU: state_nxt = Process_Data ? IDLE : WR_THRU;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state only
    always_comb begin
        SelecMemCPU       = (state == RD_MISS) || (state == WR_MISS);
        ReadEnableTag     = (state == TAG) || (state == RD_HIT);
        ReadEnableData    = (state == RD_HIT);
        gen_reset         = (state == TAG);
        write_enable_ram  = (state == RD_MISS) || (state == WR_MISS) || (state == WR_HIT);
        enable_contadores = (state == RD_MISS) || (state == WR_MISS);
        count_read        = (state == RD_MISS);
        salida            = state;
    end
endmodule

// File: tb/tb_fsm.sv
// tb_fsm: directed and random checks of the cache control FSM against a reference model
module tb_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hit = 1'b0, Run = 1'b0, RW = 1'b0;
    logic       Data_Ready = 1'b0, Data_ReadyM = 1'b0, Process_Data = 1'b0;
    logic       SelecMemCPU, ReadEnableTag, ReadEnableData, gen_reset;
    logic       write_enable_ram, enable_contadores, count_read;
    logic [2:0] salida;

    int n_chk = 0;
    int n_fail = 0;
    int ms = 0;

    // expected {SelecMemCPU,ReadEnableTag,ReadEnableData,gen_reset,write_enable_ram,enable_contadores,count_read}
    logic [6:0] exp_out [8];

    fsm dut (
        .clk(clk), .reset(reset), .hit(hit), .Run(Run), .RW(RW),
        .Data_Ready(Data_Ready), .Data_ReadyM(Data_ReadyM), .Process_Data(Process_Data),
        .SelecMemCPU(SelecMemCPU), .ReadEnableTag(ReadEnableTag), .ReadEnableData(ReadEnableData),
        .gen_reset(gen_reset), .write_enable_ram(write_enable_ram),
        .enable_contadores(enable_contadores), .count_read(count_read), .salida(salida)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {SelecMemCPU, ReadEnableTag, ReadEnableData, gen_reset,
                write_enable_ram, enable_contadores, count_read};
    endfunction

    function automatic int model_next(int s);
        if (s == 0) return Run ? 1 : 0;
        if (s == 1) return hit ? (RW ? 4 : 2) : (RW ? 5 : 3);
        if (s == 2) return Data_Ready ? 0 : 2;
        if (s == 3 || s == 5) return Data_ReadyM ? 1 : s;
        if (s == 4) return 6;
        if (s == 6) return Process_Data ? 0 : 6;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_state"}, {7'd0, salida}, 10'(ms));
        chk({tag, "_outs"}, {3'd0, outs()}, {3'd0, exp_out[ms]});
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        ms = model_next(ms);
        #1 chk_model(tag);
    endtask

    task automatic idle_inputs();
        {hit, Run, RW, Data_Ready, Data_ReadyM, Process_Data} = 6'b0;
    endtask

    initial begin
        exp_out[0] = 7'b0000000;
        exp_out[1] = 7'b0101000;
        exp_out[2] = 7'b0110000;
        exp_out[3] = 7'b1000111;
        exp_out[4] = 7'b0000100;
        exp_out[5] = 7'b1000110;
        exp_out[6] = 7'b0000000;
        exp_out[7] = 7'b0000000;

        // reset with random inputs
        #2 reset = 1'b0;
        {hit, Run, RW, Data_Ready, Data_ReadyM, Process_Data} = 6'($urandom);
        #1 chk("rst_async_salida", {7'd0, salida}, 10'd0);
        chk("rst_async_outs", {3'd0, outs()}, 10'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            {hit, Run, RW, Data_Ready, Data_ReadyM, Process_Data} = 6'($urandom);
            #1 chk_model("rst_hold");
        end
        idle_inputs();
        @(negedge clk) reset = 1'b1;
        repeat (3) tick("idle_run0");

        // write miss, refill, then hit and write-through
        Run = 1; RW = 1; hit = 0;
        tick("wm_tag"); chk("wm_s1", {7'd0, salida}, 10'd1);
        tick("wm_miss"); chk("wm_s5", {7'd0, salida}, 10'd5);
        chk("wm_sel_en", {8'd0, SelecMemCPU, enable_contadores}, 10'b11);
        Run = 0;
        tick("wm_wait");
        Data_ReadyM = 1;
        tick("wm_refilled"); chk("wm_s1b", {7'd0, salida}, 10'd1);
        Data_ReadyM = 0; hit = 1;
        tick("wh"); chk("wh_s4", {7'd0, salida}, 10'd4);
        tick("wt"); chk("wt_s6", {7'd0, salida}, 10'd6);
        tick("wt_wait");
        Process_Data = 1;
        tick("wt_done"); chk("wt_s0", {7'd0, salida}, 10'd0);
        idle_inputs();

        // read hit with delayed acknowledge
        Run = 1; RW = 0; hit = 1;
        tick("rh_tag"); chk("rh_gen_reset", {9'd0, gen_reset}, 10'd1);
        Run = 0;
        tick("rh"); chk("rh_red", {9'd0, ReadEnableData}, 10'd1);
        repeat (3) begin tick("rh_hold"); chk("rh_s2", {7'd0, salida}, 10'd2); end
        Data_Ready = 1;
        tick("rh_done"); chk("rh_s0", {7'd0, salida}, 10'd0);
        idle_inputs();

        // read miss
        Run = 1; RW = 0; hit = 0;
        tick("rm_tag");
        tick("rm"); chk("rm_s3", {7'd0, salida}, 10'd3);
        chk("rm_cr_we", {8'd0, count_read, write_enable_ram}, 10'b11);
        Run = 0;
        repeat (3) tick("rm_hold");
        Data_ReadyM = 1;
        tick("rm_refilled"); chk("rm_s1", {7'd0, salida}, 10'd1);
        Data_ReadyM = 0; hit = 1;
        tick("rm_hit");
        Data_Ready = 1;
        tick("rm_done");
        idle_inputs();

        // spurious handshakes in IDLE
        Data_Ready = 1; Process_Data = 1; Data_ReadyM = 1;
        repeat (3) begin tick("spur"); chk("spur_s0", {7'd0, salida}, 10'd0); end
        idle_inputs();

        // reset in the middle of a write miss
        Run = 1; RW = 1;
        tick("mr_tag");
        tick("mr_miss"); chk("mr_s5", {7'd0, salida}, 10'd5);
        #2 reset = 1'b0;
        #1 chk("mr_async_salida", {7'd0, salida}, 10'd0);
        chk("mr_async_outs", {3'd0, outs()}, 10'd0);
        ms = 0;
        idle_inputs();
        @(negedge clk) reset = 1'b1;
        tick("mr_after");

        // random stimulus
        for (int i = 0; i < 500; i++) begin
            {hit, RW, Data_Ready, Data_ReadyM, Process_Data} = 5'($urandom);
            Run = ($urandom_range(0, 3) == 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
